// File: rtl/rift2_mem_port_arbiter.sv
// rift2 memory/debug port arbiter: shares the core's single memory port between the
// Wishbone slave window and the logic-analyzer debug requester, one transaction at a time.
module rift2_mem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] WIN_MASK  = 32'h0000_FFFF,
    parameter int          ADDR_W    = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              la_valid_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_adr_i,
    input  logic [31:0]       la_dat_i,
    output logic              la_ready_o,
    output logic              la_rsp_valid_o,
    output logic [31:0]       la_rsp_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic              timeout_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {SRC_WB, SRC_LA} src_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_t      state, state_nxt;
    src_t        owner, last;
    logic [15:0] cnt;
    logic        wb_hit, wb_req, la_req;
    logic        grant_wb, grant_la;
    logic        expired;
    logic [31:0] resp_data;

    assign wb_hit = ((wbs_adr_i & ~WIN_MASK) == BASE_ADDR);
    assign wb_req = wbs_cyc_i & wbs_stb_i & wb_hit;
    assign la_req = la_valid_i;

    // On a tie the requester that was not served last wins.
    assign grant_wb = (state == S_IDLE) && wb_req && (!la_req || (last == SRC_LA));
    assign grant_la = (state == S_IDLE) && la_req && !grant_wb;

    assign expired   = (cnt == TO_LIMIT);
    assign resp_data = timeout_o ? ERR_DATA : mem_rdata_i;

    always_comb begin
        state_nxt      = state;
        timeout_o      = 1'b0;
        mem_req_o      = 1'b0;
        wbs_ack_o      = 1'b0;
        la_rsp_valid_o = 1'b0;
        la_ready_o     = grant_la && wb_rst_n_i;
        case (state)
            S_IDLE: begin
                if (grant_wb || grant_la)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (expired) begin
                    timeout_o = 1'b1;
                    state_nxt = S_RESP;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_gnt_i)
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt = S_RESP;
                end else if (expired) begin
                    timeout_o = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A master that dropped cyc has abandoned the cycle, so it gets no ack.
                wbs_ack_o      = (owner == SRC_WB) && wbs_cyc_i;
                la_rsp_valid_o = (owner == SRC_LA);
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state         <= S_IDLE;
            owner         <= SRC_WB;
            last          <= SRC_LA;
            cnt           <= '0;
            mem_we_o      <= 1'b0;
            mem_wstrb_o   <= '0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            wbs_dat_o     <= '0;
            la_rsp_data_o <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_ISSUE || state == S_WAIT)
                cnt <= cnt + 16'd1;
            else
                cnt <= '0;

            if (grant_wb) begin
                owner       <= SRC_WB;
                last        <= SRC_WB;
                mem_we_o    <= wbs_we_i;
                mem_wstrb_o <= wbs_sel_i;
                mem_addr_o  <= wbs_adr_i[ADDR_W-1:0];
                mem_wdata_o <= wbs_dat_i;
            end else if (grant_la) begin
                owner       <= SRC_LA;
                last        <= SRC_LA;
                mem_we_o    <= la_we_i;
                mem_wstrb_o <= 4'hF;
                mem_addr_o  <= la_adr_i;
                mem_wdata_o <= la_dat_i;
            end

            // Response data is latched on entry to RESP and held until the next response.
            if (state != S_RESP && state_nxt == S_RESP) begin
                if (owner == SRC_WB)
                    wbs_dat_o <= mem_we_o ? 32'h0 : resp_data;
                else
                    la_rsp_data_o <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_rift2_mem_port_arbiter.sv
// Directed testbench for rift2_mem_port_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_rift2_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        la_valid_i, la_we_i;
    logic [15:0] la_adr_i;
    logic [31:0] la_dat_i;
    logic        la_ready_o, la_rsp_valid_o;
    logic [31:0] la_rsp_data_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_wstrb_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        timeout_o;

    int total = 0;
    int bad   = 0;

    rift2_mem_port_arbiter #(
        .BASE_ADDR(32'h3000_0000),
        .WIN_MASK (32'h0000_FFFF),
        .ADDR_W   (16),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_n_i    (rst_n),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .la_valid_i    (la_valid_i),
        .la_we_i       (la_we_i),
        .la_adr_i      (la_adr_i),
        .la_dat_i      (la_dat_i),
        .la_ready_o    (la_ready_o),
        .la_rsp_valid_o(la_rsp_valid_o),
        .la_rsp_data_o (la_rsp_data_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_wstrb_o   (mem_wstrb_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .timeout_o     (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        wbs_cyc_i    = 1'b0;
        wbs_stb_i    = 1'b0;
        wbs_we_i     = 1'b0;
        wbs_sel_i    = 4'h0;
        wbs_adr_i    = 32'h0;
        wbs_dat_i    = 32'h0;
        la_valid_i   = 1'b0;
        la_we_i      = 1'b0;
        la_adr_i     = 16'h0;
        la_dat_i     = 32'h0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack got=%b want=0", wbs_ack_o); end
        total++; if (wbs_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_wbs_dat got=%h want=0", wbs_dat_o); end
        total++; if (la_rsp_valid_o !== 1'b0 || la_ready_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_la_flags got=%b%b want=00", la_rsp_valid_o, la_ready_o); end
        total++; if (la_rsp_data_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_la_data got=%h want=0", la_rsp_data_o); end
        total++; if ({mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, timeout_o} !== 55'h0) begin bad++; $display("[TB] FAIL reset_mem_fields req=%b we=%b strb=%h addr=%h wdata=%h to=%b want all 0", mem_req_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_wdata_o, timeout_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wb_read();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0010; mem_gnt_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_idle_req got=%b want=0", mem_req_o); end
        @(negedge clk); #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_issue_req got=%b want=1", mem_req_o); end
        total++; if (mem_addr_o !== 16'h0010) begin bad++; $display("[TB] FAIL rd_addr got=%h want=0010", mem_addr_o); end
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #1;
        total++; if (mem_req_o !== 1'b0 || wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_wait req=%b ack=%b want 0 0", mem_req_o, wbs_ack_o); end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (wbs_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL rd_ack got=%b want=1", wbs_ack_o); end
        total++; if (wbs_dat_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rd_data got=%h want=12345678", wbs_dat_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rd_ack_one_cycle got=%b want=0", wbs_ack_o); end
        total++; if (wbs_dat_o !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rd_data_hold got=%h want=12345678", wbs_dat_o); end
    endtask

    task automatic test_wb_write();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b0011;
        wbs_adr_i = 32'h3000_0020; wbs_dat_i = 32'hA5A5_0000; mem_gnt_i = 1'b1;
        @(negedge clk); #1;
        total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_issue req=%b we=%b want 1 1", mem_req_o, mem_we_o); end
        total++; if (mem_wstrb_o !== 4'b0011) begin bad++; $display("[TB] FAIL wr_strb got=%b want=0011", mem_wstrb_o); end
        total++; if (mem_wdata_o !== 32'hA5A5_0000 || mem_addr_o !== 16'h0020) begin bad++; $display("[TB] FAIL wr_payload data=%h addr=%h want a5a50000 0020", mem_wdata_o, mem_addr_o); end
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (wbs_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL wr_ack got=%b want=1", wbs_ack_o); end
        total++; if (wbs_dat_o !== 32'h0) begin bad++; $display("[TB] FAIL wr_ack_data got=%h want=0", wbs_dat_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'b0101;
        wbs_adr_i = 32'h3000_0004;
        la_valid_i = 1'b1; la_we_i = 1'b0; la_adr_i = 16'h0040;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        for (int t = 0; t < 4; t++) begin
            logic exp_la;
            exp_la = (t % 2 == 1);
            if (t != 0) @(negedge clk);
            #1;
            total++; if (la_ready_o !== exp_la) begin bad++; $display("[TB] FAIL rr_ready_%0d got=%b want=%b", t, la_ready_o, exp_la); end
            @(negedge clk); #1;
            total++; if (mem_addr_o !== (exp_la ? 16'h0040 : 16'h0004) || mem_wstrb_o !== (exp_la ? 4'hF : 4'b0101)) begin bad++; $display("[TB] FAIL rr_owner_%0d addr=%h strb=%b want_la=%b", t, mem_addr_o, mem_wstrb_o, exp_la); end
            @(negedge clk);
            @(negedge clk); #1;
            total++; if (wbs_ack_o !== !exp_la || la_rsp_valid_o !== exp_la) begin bad++; $display("[TB] FAIL rr_resp_%0d ack=%b la_rsp=%b want_la=%b", t, wbs_ack_o, la_rsp_valid_o, exp_la); end
            if (exp_la) begin
                total++; if (la_rsp_data_o !== 32'h1111_2222) begin bad++; $display("[TB] FAIL rr_la_data_%0d got=%h want=11112222", t, la_rsp_data_o); end
            end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (wbs_ack_o !== 1'b0 || la_rsp_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL rr_no_back_to_back ack=%b la_rsp=%b want 0 0", wbs_ack_o, la_rsp_valid_o); end
    endtask

    task automatic test_la_write();
        @(negedge clk);
        la_valid_i = 1'b1; la_we_i = 1'b1; la_adr_i = 16'h0080; la_dat_i = 32'h0BAD_F00D;
        mem_gnt_i = 1'b1;
        #1;
        total++; if (la_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL law_ready got=%b want=1", la_ready_o); end
        @(negedge clk);
        la_valid_i = 1'b0;
        #1;
        total++; if (mem_we_o !== 1'b1 || mem_wdata_o !== 32'h0BAD_F00D || mem_wstrb_o !== 4'hF) begin bad++; $display("[TB] FAIL law_issue we=%b data=%h strb=%h want 1 0badf00d f", mem_we_o, mem_wdata_o, mem_wstrb_o); end
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (la_rsp_valid_o !== 1'b1 || la_rsp_data_o !== 32'h5555_AAAA) begin bad++; $display("[TB] FAIL law_resp valid=%b data=%h want 1 5555aaaa", la_rsp_valid_o, la_rsp_data_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0008;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            total++; if (mem_req_o !== 1'b1 || timeout_o !== 1'b0) begin bad++; $display("[TB] FAIL to_pending_%0d req=%b to=%b want 1 0", i, mem_req_o, timeout_o); end
        end
        @(negedge clk); #1;
        total++; if (mem_req_o !== 1'b0 || timeout_o !== 1'b1) begin bad++; $display("[TB] FAIL to_abort req=%b to=%b want 0 1", mem_req_o, timeout_o); end
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0000;
        #1;
        total++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hDEAD_BEEF || timeout_o !== 1'b0) begin bad++; $display("[TB] FAIL to_resp ack=%b data=%h to=%b want 1 deadbeef 0", wbs_ack_o, wbs_dat_o, timeout_o); end
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (wbs_ack_o !== 1'b0 || mem_req_o !== 1'b0 || wbs_dat_o !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL to_late_rvalid ack=%b req=%b data=%h want 0 0 deadbeef", wbs_ack_o, mem_req_o, wbs_dat_o); end
        clear_inputs();
    endtask

    task automatic test_out_of_window();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = 32'h2000_0000; wbs_sel_i = 4'hF;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (mem_req_o !== 1'b0 || wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL oow_%0d req=%b ack=%b want 0 0", i, mem_req_o, wbs_ack_o); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_master_abort();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0030; mem_gnt_i = 1'b1;
        @(negedge clk); #1;
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("[TB] FAIL abort_issue got=%b want=1", mem_req_o); end
        @(negedge clk);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; mem_gnt_i = 1'b0;
        @(negedge clk);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_8888;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (wbs_ack_o !== 1'b0 || la_rsp_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_ack ack=%b la_rsp=%b want 0 0", wbs_ack_o, la_rsp_valid_o); end
        @(negedge clk); #1;
        total++; if (mem_req_o !== 1'b0 || timeout_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_idle req=%b to=%b want 0 0", mem_req_o, timeout_o); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0044; wbs_dat_i = 32'h1357_9BDF; mem_gnt_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (mem_wdata_o !== 32'h0 || mem_addr_o !== 16'h0 || mem_we_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_mem wdata=%h addr=%h we=%b want 0", mem_wdata_o, mem_addr_o, mem_we_o); end
        total++; if (wbs_dat_o !== 32'h0 || la_rsp_data_o !== 32'h0 || wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_rsp wdat=%h ladat=%h ack=%b want 0", wbs_dat_o, la_rsp_data_o, wbs_ack_o); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        la_valid_i = 1'b1; la_we_i = 1'b0; la_adr_i = 16'h0100; mem_gnt_i = 1'b1;
        #1;
        total++; if (la_ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_la_ready got=%b want=1", la_ready_o); end
        @(negedge clk);
        la_valid_i = 1'b0;
        #1;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0100 || mem_wstrb_o !== 4'hF) begin bad++; $display("[TB] FAIL rstmid_la_issue req=%b addr=%h strb=%h want 1 0100 f", mem_req_o, mem_addr_o, mem_wstrb_o); end
        @(negedge clk);
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD_0123;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        #1;
        total++; if (la_rsp_valid_o !== 1'b1 || la_rsp_data_o !== 32'hABCD_0123 || wbs_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_la_resp valid=%b data=%h ack=%b want 1 abcd0123 0", la_rsp_valid_o, la_rsp_data_o, wbs_ack_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_wb_write();
        test_round_robin();
        test_la_write();
        test_timeout();
        test_out_of_window();
        test_master_abort();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
